cuenta_atras: RTL and testbench

CUENTA_ATRAS -- requirements
Module: cuenta_atras

---
 rtl/cuenta_atras.sv | 136 +++++++++++++
 tb/tb_cuenta_atras.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cuenta_atras.sv
// ---------------------------------------------------------------------------
// cuenta_atras -- loadable down-counter with run / pause control.
//
// A value is loaded while the counter is idle (or paused), then each tick
// pulse decrements it while running.  Reaching zero produces a one-cycle
// done pulse.  With RELOAD=1 the counter restarts from the last loaded value
// after each expiry unless stop is held during the done cycle or that value
// is zero.
//
// Parameters
//   WIDTH   width of count / load value (intended range 2..16)
//   RELOAD  1 = automatic reload and restart after expiry
//
// Ports
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   tick        in   decrement qualifier (one-cycle prescaler pulse)
//   load        in   capture load_value into count and reload register
//   load_value  in   WIDTH  value to load
//   start       in   start / resume request
//   stop        in   pause request
//   count       out  WIDTH  remaining count (registered)
//   busy        out  high while running or paused
//   done        out  one-cycle pulse per expiry (registered)
//   zero        out  combinational, count == 0
// ---------------------------------------------------------------------------
module cuenta_atras #(
  parameter int WIDTH  = 8,
  parameter bit RELOAD = 1'b0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;

    case (state_q)
      S_IDLE: begin
        // A simultaneous start is dropped; only the load happens this cycle.
        if (load) begin
          count_d  = load_value;
          reload_d = load_value;
        end else if (start) begin
          state_d = (count_q == '0) ? S_DONE : S_RUN;
        end
      end

      S_RUN: begin
        // stop wins over tick, so a coincident tick is lost.
        if (stop) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          // <= also covers a zero count, so the counter can never wrap.
          if (count_q <= ONE) begin
            count_d = '0;
            state_d = S_DONE;
          end else begin
            count_d = count_q - ONE;
          end
        end
      end

      S_PAUSE: begin
        if (load) begin
          count_d  = load_value;
          reload_d = load_value;
          state_d  = S_IDLE;
        end else if (start && !stop) begin
          state_d = S_RUN;
        end
      end

      S_DONE: begin
        count_d = '0;
        state_d = S_IDLE;
        if (RELOAD && !stop && (reload_q != '0)) begin
          count_d = reload_q;
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // done is its own flop so it is a clean registered pulse for one cycle.
  assign done_d = (state_d == S_DONE);

  assign count = count_q;
  assign busy  = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done  = done_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_cuenta_atras.sv
// ---------------------------------------------------------------------------
// tb_cuenta_atras -- scoreboard bench for cuenta_atras.
//
// Two instances share one stimulus stream: RELOAD=0 (dut 0) and RELOAD=1
// (dut 1).  Each clock the stimulus process advances a behavioural model of
// both counters and queues the expected outputs; a monitor pops one entry
// per falling edge (or on an asynchronous reset strobe) and compares.
// ---------------------------------------------------------------------------
module tb_cuenta_atras;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         zero;
  } obs_t;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         tick = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         reset_chk = 1'b0;

  logic [W-1:0] count_w [2];
  logic         busy_w  [2];
  logic         done_w  [2];
  logic         zero_w  [2];

  int checks   = 0;
  int failures = 0;

  obs_t exp_q0[$];
  obs_t exp_q1[$];

  // Behavioural model: remaining time plus activity flags per instance.
  int rem        [2];
  int reload_val [2];
  bit running    [2];
  bit paused     [2];
  bit expiring   [2];

  always #5 clock = ~clock;

  cuenta_atras #(.WIDTH(W), .RELOAD(1'b0)) dut0 (
    .clock(clock), .reset_n(reset_n), .tick(tick), .load(load),
    .load_value(load_value), .start(start), .stop(stop),
    .count(count_w[0]), .busy(busy_w[0]), .done(done_w[0]), .zero(zero_w[0])
  );

  cuenta_atras #(.WIDTH(W), .RELOAD(1'b1)) dut1 (
    .clock(clock), .reset_n(reset_n), .tick(tick), .load(load),
    .load_value(load_value), .start(start), .stop(stop),
    .count(count_w[1]), .busy(busy_w[1]), .done(done_w[1]), .zero(zero_w[1])
  );

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; reload_val[i] = 0;
      running[i] = 0; paused[i] = 0; expiring[i] = 0;
    end
  endfunction

  // One clock of the counter rules; instance i restarts after expiry when
  // auto_reload is set.
  function automatic void model_step(input int i, input bit auto_reload);
    if (expiring[i]) begin
      expiring[i] = 0;
      if (auto_reload && !stop && reload_val[i] != 0) begin
        rem[i] = reload_val[i];
        running[i] = 1;
      end
    end else if (running[i]) begin
      if (stop) begin
        running[i] = 0; paused[i] = 1;
      end else if (tick) begin
        if (rem[i] > 0) rem[i] = rem[i] - 1;
        if (rem[i] == 0) begin
          running[i] = 0; expiring[i] = 1;
        end
      end
    end else if (paused[i]) begin
      if (load) begin
        rem[i] = int'(load_value); reload_val[i] = int'(load_value); paused[i] = 0;
      end else if (start && !stop) begin
        paused[i] = 0; running[i] = 1;
      end
    end else begin
      if (load) begin
        rem[i] = int'(load_value); reload_val[i] = int'(load_value);
      end else if (start) begin
        if (rem[i] == 0) expiring[i] = 1;
        else running[i] = 1;
      end
    end
  endfunction

  function automatic obs_t model_obs(input int i);
    obs_t o;
    o.count = W'(rem[i]);
    o.busy  = running[i] | paused[i];
    o.done  = expiring[i];
    o.zero  = (rem[i] == 0);
    return o;
  endfunction

  function automatic void push_expected();
    exp_q0.push_back(model_obs(0));
    exp_q1.push_back(model_obs(1));
  endfunction

  task automatic compare(input int i, input obs_t e);
    obs_t a;
    a.count = count_w[i];
    a.busy  = busy_w[i];
    a.done  = done_w[i];
    a.zero  = zero_w[i];
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL outputs_dut%0d t=%0t actual count=%0d busy=%b done=%b zero=%b required count=%0d busy=%b done=%b zero=%b",
               i, $time, a.count, a.busy, a.done, a.zero, e.count, e.busy, e.done, e.zero);
    end
    if (e.done && a.done === 1'b1)
      $display("txn: dut%0d (RELOAD=%0d) expiry pulse at t=%0t", i, i, $time);
  endtask

  // Monitor: outputs are presented every cycle, plus on the reset strobe.
  initial begin
    obs_t e0, e1;
    forever begin
      @(negedge clock or posedge reset_chk);
      if (exp_q0.size() > 0 && exp_q1.size() > 0) begin
        e0 = exp_q0.pop_front();
        e1 = exp_q1.pop_front();
        compare(0, e0);
        compare(1, e1);
      end
    end
  end

  task automatic cyc(input bit t, input bit ld, input logic [W-1:0] lv,
                     input bit st, input bit sp);
    tick = t; load = ld; load_value = lv; start = st; stop = sp;
    @(posedge clock);
    if (!reset_n) model_reset();
    else begin
      model_step(0, 1'b0);
      model_step(1, 1'b1);
    end
    push_expected();
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, '0, 0, 0);
  endtask

  // Mid-cycle asynchronous reset, checked before the next edge, held across
  // one edge and released away from the edge.
  task automatic reset_pulse();
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    model_reset();
    push_expected();
    #1 reset_chk = 1'b1;
    #1 reset_chk = 1'b0;
    cyc(0, 0, '0, 0, 0);
    reset_n = 1'b1;
  endtask

  // Brings both instances back to idle regardless of where they are.
  task automatic to_idle();
    cyc(0, 0, '0, 0, 1);
    cyc(0, 1, '0, 0, 0);
    idle_cycles(1);
  endtask

  initial begin
    logic [W-1:0] lv;
    model_reset();

    // Reset held across two edges, then released.
    cyc(0, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 0);
    reset_n = 1'b1;
    idle_cycles(2);

    // Load 3, start, three ticks four cycles apart.
    $display("txn: scenario load3/start/three ticks");
    cyc(0, 1, 8'd3, 0, 0);
    cyc(0, 0, '0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, '0, 0, 0);
      idle_cycles(3);
    end
    to_idle();

    // Stop and tick together at count 5, tick while paused, resume.
    $display("txn: scenario pause at 5");
    cyc(0, 1, 8'd6, 0, 0);
    cyc(0, 0, '0, 1, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 1);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 1, 0);
    cyc(1, 0, '0, 0, 0);
    idle_cycles(1);
    to_idle();

    // Load and start together: load only, then start.
    $display("txn: scenario load+start 7");
    cyc(0, 1, 8'd7, 1, 0);
    cyc(0, 0, '0, 1, 0);
    idle_cycles(2);
    to_idle();

    // Start with a zero count.
    $display("txn: scenario start at zero");
    cyc(0, 0, '0, 1, 0);
    idle_cycles(2);

    // Expiry with reload, then stop during the done cycle.
    $display("txn: scenario reload 2");
    cyc(0, 1, 8'd2, 0, 0);
    cyc(0, 0, '0, 1, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(1, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 1);
    idle_cycles(2);
    to_idle();

    // Reset while running at 9.
    $display("txn: scenario reset at count 9");
    cyc(0, 1, 8'd9, 0, 0);
    cyc(0, 0, '0, 1, 0);
    idle_cycles(2);
    reset_pulse();
    idle_cycles(3);

    // Randomised traffic.
    $display("txn: random phase");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 9) == 0) lv = W'($urandom_range(0, 255));
      else lv = W'($urandom_range(0, 4));
      if ($urandom_range(0, 199) == 0)
        reset_pulse();
      else
        cyc($urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0, lv,
            $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0);
    end
    idle_cycles(1);

    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual pending=%0d required pending=0",
               exp_q0.size() + exp_q1.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
